traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Passive checker on the lamp outputs (red/yellow/green) of traffic_light_controller.
//  Tracks the observed phase, measures how long each phase lasts, and flags illegal lamp
//  patterns, illegal phase order and out-of-range phase durations. It also counts completed
//  light cycles.
//  Sits beside the controller in the top level and in benches; it drives nothing back.
// PARAMETERS
//  RED_MIN    5   min legal red dwell, clk cycles
//  RED_MAX    12  max legal red dwell, clk cycles
//  GREEN_MIN  5   min legal green dwell
//  GREEN_MAX  12  max legal green dwell
//  YEL_MIN    2   min legal yellow dwell
//  YEL_MAX    4   max legal yellow dwell
//  CNT_W      8   width of dwell and cycle counters (every *_MAX < 2**CNT_W-1)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      synchronous, active-high
//  red          in   1      red lamp from controller
//  yellow       in   1      yellow lamp from controller
//  green        in   1      green lamp from controller
//  phase        out  2      tracked phase: 0=UNK 1=RED 2=GREEN 3=YELLOW
//  dwell        out  CNT_W  cycles the current phase has been held (saturating)
//  cycle_count  out  CNT_W  completed legal YELLOW->RED transitions, wraps
//  err_onehot   out  1      sticky: lamp pattern other than exactly one lamp seen
//  err_seq      out  1      sticky: illegal phase transition seen
//  err_dwell    out  1      sticky: phase shorter than MIN or longer than MAX
//  err_pulse    out  1      1-cycle pulse on any new error event
// BEHAVIOUR
//  - Reset (sampled at posedge): phase=UNK, dwell=0, cycle_count=0, all err_*=0.
//    Reset dominates every other event in the same cycle and may occur mid-phase.
//  - Inputs are sampled each posedge; all outputs are registered, so every result
//    appears 1 cycle after the sample that causes it.
//  - Decode lamp: exactly one of {red, green, yellow} high -> that phase. Any other
//    pattern -> INVALID.
//  - INVALID sample: err_onehot=1, err_pulse=1, phase->UNK, dwell->0. No seq or dwell check.
//  - UNK + valid lamp: phase->lamp, dwell->1, no order check (resync). The first phase after
//    UNK is partial, so its MIN check is skipped. Its MAX check still applies.
//  - Same valid lamp as phase: dwell+1, saturating at 2**CNT_W-1.
//    When dwell==X_MAX and the lamp is still the same: err_dwell=1, err_pulse=1 once per
//    phase instance. The flag is set on the cycle dwell would go to X_MAX+1.
//  - Different valid lamp (phase change):
//    legal order RED->GREEN, GREEN->YELLOW, YELLOW->RED; any other pair -> err_seq=1.
//    Leaving a non-partial phase with dwell<X_MIN -> err_dwell=1.
//    Legal YELLOW->RED -> cycle_count+1, wrapping at 2**CNT_W.
//    phase->new lamp, dwell->1. The new phase is non-partial even after an err_seq.
//  - Seq error and short-dwell error in the same cycle: both flags set, one err_pulse.
//  - err_pulse is asserted only if a flag transitions or the event is new. A repeated INVALID
//    sample re-pulses each cycle. Sticky flags clear only on reset.
// TESTING
//  1 reset=1 for 2 cycles, lamps x -> all outputs 0, phase=0 on the cycle after release.
//  2 drive R6,G6,Y3 for two full loops -> cycle_count=2, no err_*; dwell peaks 6/6/3.
//  3 R6 then Y3 (skip green) -> err_seq=1 and err_pulse for 1 cycle, 1 cycle after yellow
//    first seen; phase=3.
//  4 R6,G13 -> err_dwell=1 on the sample where green holds its 13th cycle; R6,G6,Y1,R ->
//    err_dwell on the change to red.
//  5 red=green=1 for 1 cycle mid-red -> err_onehot=1, phase=0. Then G3,Y3 -> no err_dwell
//    (partial green), phase=3.
//  6 reset pulse mid-green after an error -> flags, cycle_count and dwell all 0. CNT_W=3
//    build with 8 loops -> cycle_count wraps to 0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive checker for red/yellow/green lamp outputs: tracks the phase and its dwell,
// counts completed light cycles, and raises sticky errors for bad patterns, order and timing.
module traffic_light_monitor #(
    parameter int RED_MIN   = 5,
    parameter int RED_MAX   = 12,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 12,
    parameter int YEL_MIN   = 2,
    parameter int YEL_MAX   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             err_dwell,
    output logic             err_pulse
);

    typedef enum logic [1:0] {
        PH_UNK   = 2'd0,
        PH_RED   = 2'd1,
        PH_GREEN = 2'd2,
        PH_YEL   = 2'd3
    } phase_t;

    phase_t           phase_q, phase_n;
    logic [CNT_W-1:0] dwell_q, dwell_n;
    logic [CNT_W-1:0] cyc_q, cyc_n;
    logic             partial_q, partial_n;
    logic             eo_q, eo_n;
    logic             es_q, es_n;
    logic             ed_q, ed_n;
    logic             ep_q, ep_n;

    phase_t           lamp;
    logic             lamp_ok;
    logic [CNT_W-1:0] cur_min;
    logic [CNT_W-1:0] cur_max;
    logic             legal;
    logic             short_dw;

    always_comb begin
        lamp    = PH_UNK;
        lamp_ok = 1'b1;
        case ({red, yellow, green})
            3'b100:  lamp = PH_RED;
            3'b010:  lamp = PH_YEL;
            3'b001:  lamp = PH_GREEN;
            default: lamp_ok = 1'b0;
        endcase
    end

    always_comb begin
        cur_min = '0;
        cur_max = '1;
        case (phase_q)
            PH_RED: begin
                cur_min = CNT_W'(RED_MIN);
                cur_max = CNT_W'(RED_MAX);
            end
            PH_GREEN: begin
                cur_min = CNT_W'(GREEN_MIN);
                cur_max = CNT_W'(GREEN_MAX);
            end
            PH_YEL: begin
                cur_min = CNT_W'(YEL_MIN);
                cur_max = CNT_W'(YEL_MAX);
            end
            default: ;
        endcase
    end

    assign legal = (phase_q == PH_RED   && lamp == PH_GREEN) ||
                   (phase_q == PH_GREEN && lamp == PH_YEL)   ||
                   (phase_q == PH_YEL   && lamp == PH_RED);
    // A phase entered from UNK was not seen from its start, so its MIN is unknowable
    assign short_dw = !partial_q && (dwell_q < cur_min);

    always_comb begin
        phase_n   = phase_q;
        dwell_n   = dwell_q;
        cyc_n     = cyc_q;
        partial_n = partial_q;
        eo_n      = eo_q;
        es_n      = es_q;
        ed_n      = ed_q;
        ep_n      = 1'b0;
        if (!lamp_ok) begin
            eo_n      = 1'b1;
            ep_n      = 1'b1;
            phase_n   = PH_UNK;
            dwell_n   = '0;
            partial_n = 1'b0;
        end else if (phase_q == PH_UNK) begin
            phase_n   = lamp;
            dwell_n   = CNT_W'(1);
            partial_n = 1'b1;
        end else if (lamp == phase_q) begin
            if (dwell_q != '1)
                dwell_n = dwell_q + CNT_W'(1);
            // Dwell passes MAX exactly once per phase instance
            if (dwell_q == cur_max) begin
                ed_n = 1'b1;
                ep_n = 1'b1;
            end
        end else begin
            if (!legal)
                es_n = 1'b1;
            if (short_dw)
                ed_n = 1'b1;
            ep_n = !legal || short_dw;
            if (legal && phase_q == PH_YEL)
                cyc_n = cyc_q + CNT_W'(1);
            phase_n   = lamp;
            dwell_n   = CNT_W'(1);
            partial_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= PH_UNK;
            dwell_q   <= '0;
            cyc_q     <= '0;
            partial_q <= 1'b0;
            eo_q      <= 1'b0;
            es_q      <= 1'b0;
            ed_q      <= 1'b0;
            ep_q      <= 1'b0;
        end else begin
            phase_q   <= phase_n;
            dwell_q   <= dwell_n;
            cyc_q     <= cyc_n;
            partial_q <= partial_n;
            eo_q      <= eo_n;
            es_q      <= es_n;
            ed_q      <= ed_n;
            ep_q      <= ep_n;
        end
    end

    assign phase       = phase_q;
    assign dwell       = dwell_q;
    assign cycle_count = cyc_q;
    assign err_onehot  = eo_q;
    assign err_seq     = es_q;
    assign err_dwell   = ed_q;
    assign err_pulse   = ep_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a vector table on the default build and
// a hand sequence on a narrow-counter build for wrap and saturation.
module tb_traffic_light_monitor;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] NO = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic       red, yellow, green;
    logic [1:0] phase;
    logic [7:0] dwell, cycle_count;
    logic       err_onehot, err_seq, err_dwell, err_pulse;

    logic       red_w, yellow_w, green_w;
    logic [1:0] phase_w;
    logic [2:0] dwell_w, cycle_w;
    logic       eo_w, es_w, ed_w, ep_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk(clk), .reset(reset),
        .red(red), .yellow(yellow), .green(green),
        .phase(phase), .dwell(dwell), .cycle_count(cycle_count),
        .err_onehot(err_onehot), .err_seq(err_seq),
        .err_dwell(err_dwell), .err_pulse(err_pulse)
    );

    traffic_light_monitor #(
        .RED_MIN(2), .RED_MAX(5), .GREEN_MIN(2), .GREEN_MAX(5),
        .YEL_MIN(1), .YEL_MAX(3), .CNT_W(3)
    ) dut_w (
        .clk(clk), .reset(reset),
        .red(red_w), .yellow(yellow_w), .green(green_w),
        .phase(phase_w), .dwell(dwell_w), .cycle_count(cycle_w),
        .err_onehot(eo_w), .err_seq(es_w),
        .err_dwell(ed_w), .err_pulse(ep_w)
    );

    // flags packed as {onehot, seq, dwell, pulse}
    typedef struct {
        logic       rst;
        logic [2:0] lamp;
        logic [1:0] ph;
        logic [7:0] dw;
        logic [7:0] cc;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl[$];

    task automatic one(input logic rst, input logic [2:0] lamp,
                       input logic [1:0] ph, input int dw, input int cc,
                       input logic [3:0] fl);
        vec_t v;
        v.rst  = rst;
        v.lamp = lamp;
        v.ph   = ph;
        v.dw   = 8'(dw);
        v.cc   = 8'(cc);
        v.fl   = fl;
        tbl.push_back(v);
    endtask

    task automatic hold(input logic [2:0] lamp, input int n, input logic [1:0] ph,
                        input int d0, input int cc, input logic [3:0] fl);
        for (int i = 0; i < n; i++)
            one(1'b0, lamp, ph, d0 + i, cc, fl);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step_w(input logic [2:0] lamp);
        {red_w, yellow_w, green_w} = lamp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {red, yellow, green} = 3'b111;
        {red_w, yellow_w, green_w} = NO;

        // reset with arbitrary lamps
        one(1'b1, 3'b111, 0, 0, 0, 4'b0000);
        one(1'b1, NO,     0, 0, 0, 4'b0000);
        // two clean loops, then close the second one
        hold(R, 6, 1, 1, 0, 4'b0000);
        hold(G, 6, 2, 1, 0, 4'b0000);
        hold(Y, 3, 3, 1, 0, 4'b0000);
        hold(R, 6, 1, 1, 1, 4'b0000);
        hold(G, 6, 2, 1, 1, 4'b0000);
        hold(Y, 3, 3, 1, 1, 4'b0000);
        hold(R, 6, 1, 1, 2, 4'b0000);
        // red straight to yellow
        one(1'b0, Y, 3, 1, 2, 4'b0101);
        hold(Y, 2, 3, 2, 2, 4'b0100);
        one(1'b1, Y, 0, 0, 0, 4'b0000);
        // green overstays
        hold(R, 6, 1, 1, 0, 4'b0000);
        hold(G, 12, 2, 1, 0, 4'b0000);
        one(1'b0, G, 2, 13, 0, 4'b0011);
        one(1'b0, G, 2, 14, 0, 4'b0010);
        one(1'b1, G, 0, 0, 0, 4'b0000);
        // yellow too short
        hold(R, 6, 1, 1, 0, 4'b0000);
        hold(G, 6, 2, 1, 0, 4'b0000);
        one(1'b0, Y, 3, 1, 0, 4'b0000);
        one(1'b0, R, 1, 1, 1, 4'b0011);
        hold(R, 2, 1, 2, 1, 4'b0010);
        // two lamps at once, then partial green is not short-checked
        one(1'b0, 3'b101, 0, 0, 1, 4'b1011);
        hold(G, 3, 2, 1, 1, 4'b1010);
        hold(Y, 3, 3, 1, 1, 4'b1010);
        one(1'b0, NO, 0, 0, 1, 4'b1011);
        one(1'b0, NO, 0, 0, 1, 4'b1011);
        // reset mid-green after errors
        hold(G, 2, 2, 1, 1, 4'b1010);
        one(1'b1, G, 0, 0, 0, 4'b0000);
        one(1'b0, G, 2, 1, 0, 4'b0000);
        one(1'b0, Y, 3, 1, 0, 4'b0000);
        // illegal and short together: one pulse
        one(1'b0, G, 2, 1, 0, 4'b0111);
        one(1'b0, G, 2, 2, 0, 4'b0110);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            {red, yellow, green} = tbl[i].lamp;
            @(posedge clk);
            #1;
            chk("phase", i, 32'(phase), 32'(tbl[i].ph));
            chk("dwell", i, 32'(dwell), 32'(tbl[i].dw));
            chk("cycle_count", i, 32'(cycle_count), 32'(tbl[i].cc));
            chk("flags", i, 32'({err_onehot, err_seq, err_dwell, err_pulse}),
                32'(tbl[i].fl));
        end

        // narrow build: cycle counter wrap
        reset = 1'b1;
        step_w(R);
        chk("w_reset", 0, 32'({phase_w, dwell_w, cycle_w, eo_w, es_w, ed_w, ep_w}), 32'd0);
        reset = 1'b0;
        step_w(R);
        step_w(R);
        chk("w_red", 0, 32'({phase_w, dwell_w}), 32'({2'd1, 3'd2}));
        for (int k = 1; k <= 8; k++) begin
            step_w(G);
            step_w(G);
            step_w(Y);
            step_w(R);
            step_w(R);
            if (k == 7)
                chk("w_cycle7", k, 32'(cycle_w), 32'd7);
        end
        chk("w_wrap", 8, 32'(cycle_w), 32'd0);
        chk("w_clean", 8, 32'({eo_w, es_w, ed_w, ep_w}), 32'd0);

        // partial yellow still gets its MAX check; dwell saturates
        step_w(NO);
        chk("w_invalid", 0, 32'({phase_w, dwell_w, eo_w, ep_w}), 32'({2'd0, 3'd0, 2'b11}));
        step_w(Y);
        step_w(Y);
        step_w(Y);
        chk("w_at_max", 3, 32'({dwell_w, ed_w}), 32'({3'd3, 1'b0}));
        step_w(Y);
        chk("w_over_max", 4, 32'({phase_w, dwell_w, ed_w, ep_w}),
            32'({2'd3, 3'd4, 2'b11}));
        for (int k = 0; k < 4; k++)
            step_w(Y);
        chk("w_saturate", 8, 32'({dwell_w, ed_w, ep_w}), 32'({3'd7, 2'b10}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
